hdmi_timing_ctrl: RTL and testbench

HDMI_TIMING_CTRL -- requirements
Module: hdmi_timing_ctrl

---
 rtl/hdmi_timing_pkg.sv | 32 +++
 rtl/hdmi_timing_cnt.sv | 61 ++++++
 rtl/hdmi_timing_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hdmi_timing_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI video timing controller.
package hdmi_timing_pkg;

    // Controller run state.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopPend = 2'd2
    } state_e;

    // Width of the horizontal and vertical position counters.
    localparam int unsigned CNT_W = 12;

    // 1280x720p60 default timing.
    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_H_FP     = 110;
    localparam int unsigned DEF_H_SYNC   = 40;
    localparam int unsigned DEF_H_BP     = 220;
    localparam int unsigned DEF_V_ACTIVE = 720;
    localparam int unsigned DEF_V_FP     = 5;
    localparam int unsigned DEF_V_SYNC   = 5;
    localparam int unsigned DEF_V_BP     = 20;
    localparam logic        DEF_SYNC_POL = 1'b1;

    // True when val lies in the inclusive window [lo, hi].
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Horizontal/vertical position counter pair with line wrap and end-of-frame flag.
module hdmi_timing_cnt
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
    parameter int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_run,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_h_wrap,
    output logic             o_eof
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Next position: held at origin while stopped, raster scan while running.
    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (!i_run) begin
            w_h_next = '0;
            w_v_next = '0;
        end else if (w_h_last) begin
            w_h_next = '0;
            w_v_next = w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            w_h_next = r_h_cnt + 1'b1;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;
    assign o_h_wrap = w_h_last;
    assign o_eof    = w_h_last & w_v_last;

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// HDMI 24-bit video timing controller: run FSM, pixel handshake, registered outputs.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        underflow_clr,
    output logic        hdmi_hsync,
    output logic        hdmi_vsync,
    output logic        hdmi_data_e,
    output logic [23:0] hdmi_data,
    output logic        frame_start,
    output logic        busy,
    output logic        underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_busy;
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_eof;
    logic             w_de;
    logic             w_starve;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_origin;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_data_e;
    logic [23:0]      r_data;
    logic             r_frame_start;
    logic             r_underflow;

    hdmi_timing_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_run    (w_busy),
        .o_h_cnt  (w_h_cnt),
        .o_v_cnt  (w_v_cnt),
        .o_h_wrap (w_h_wrap),
        .o_eof    (w_eof)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a stop request lets the current frame finish; re-enable always wins.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (enable) w_state_next = StRun;
            end
            StRun: begin
                if (!enable) w_state_next = StStopPend;
            end
            StStopPend: begin
                if (enable) begin
                    w_state_next = StRun;
                end else if (w_eof) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy = 1'b0;
        unique case (r_state)
            StRun, StStopPend: w_busy = 1'b1;
            default:           w_busy = 1'b0;
        endcase
    end

    assign busy      = w_busy;
    assign w_de      = w_busy & (w_h_cnt < H_ACT_END) & (w_v_cnt < V_ACT_END);
    assign pix_ready = w_de;
    assign w_starve  = w_de & ~pix_valid;
    // vsync follows v_cnt, which only moves on a line wrap, so it spans whole lines.
    assign w_hs_act  = w_busy & in_window(w_h_cnt, H_SYNC_LO, H_SYNC_HI);
    assign w_vs_act  = w_busy & in_window(w_v_cnt, V_SYNC_LO, V_SYNC_HI);
    assign w_origin  = w_busy & (w_h_cnt == '0) & (w_v_cnt == '0);

    // Output stage: one register of latency for every timing/data output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_data_e      <= 1'b0;
            r_data        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_data_e      <= w_de;
            r_data        <= (w_de & pix_valid) ? pix_data : '0;
            r_frame_start <= w_origin;
        end
    end

    // Sticky starvation flag; a new starvation beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
        end else if (w_starve) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign hdmi_hsync  = r_hsync;
    assign hdmi_vsync  = r_vsync;
    assign hdmi_data_e = r_data_e;
    assign hdmi_data   = r_data;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

    // Pixels are only ever offered inside the active window of a running frame.
    a_ready_busy: assert property (@(posedge clk) disable iff (!reset_n) pix_ready |-> busy);
    // End of frame is a line wrap by construction.
    a_eof_wrap: assert property (@(posedge clk) disable iff (!reset_n) w_eof |-> w_h_wrap);

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed bench for hdmi_timing_ctrl with a 16x8 total raster (8x4 active).
module tb_hdmi_timing_ctrl;

    localparam int FRAME = 128;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        underflow_clr;
    logic        hdmi_hsync;
    logic        hdmi_vsync;
    logic        hdmi_data_e;
    logic [23:0] hdmi_data;
    logic        frame_start;
    logic        busy;
    logic        underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hdmi_timing_ctrl #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .underflow_clr (underflow_clr),
        .hdmi_hsync    (hdmi_hsync),
        .hdmi_vsync    (hdmi_vsync),
        .hdmi_data_e   (hdmi_data_e),
        .hdmi_data     (hdmi_data),
        .frame_start   (frame_start),
        .busy          (busy),
        .underflow     (underflow)
    );

    // Outputs sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        enable        = 1'b0;
        pix_valid     = 1'b0;
        pix_data      = '0;
        underflow_clr = 1'b0;
        repeat (3) step();
        tests_run++;
        if ({busy, pix_ready, hdmi_hsync, hdmi_vsync, hdmi_data_e, frame_start, underflow}
            !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, pix_ready, hdmi_hsync, hdmi_vsync, hdmi_data_e, frame_start,
                      underflow});
        end
        tests_run++;
        if (hdmi_data !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 000000", hdmi_data);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({busy, pix_ready, hdmi_data_e, frame_start} !== 4'b0) begin
                tests_failed++;
                $display("FAIL idle_hold: got %b want 0000",
                         {busy, pix_ready, hdmi_data_e, frame_start});
            end
        end
    endtask

    task automatic test_frame();
        logic [15:0] de_mask [8];
        int fs_cnt;
        int fs_pos;
        int consumed;
        for (int v = 0; v < 8; v++) de_mask[v] = '0;
        fs_cnt   = 0;
        fs_pos   = -1;
        consumed = 0;
        enable    = 1'b1;
        pix_valid = 1'b1;
        step();
        for (int p = 0; p <= FRAME; p++) begin
            if (p > 0) begin
                int q;
                q = p - 1;
                de_mask[q / 16][q % 16] = hdmi_data_e;
                if (frame_start === 1'b1) begin
                    fs_cnt++;
                    if (fs_pos < 0) fs_pos = q;
                end
                if (hdmi_data_e === 1'b1) begin
                    tests_run++;
                    if (hdmi_data !== 24'h100000 + 24'(q)) begin
                        tests_failed++;
                        $display("FAIL frame_data pos %0d: got %h want %h", q, hdmi_data,
                                 24'h100000 + 24'(q));
                    end
                end
            end
            if (p < FRAME) begin
                if (pix_ready === 1'b1) consumed++;
                pix_data = 24'h100000 + 24'(p);
                step();
            end
        end
        tests_run++;
        if (fs_cnt !== 1 || fs_pos !== 0) begin
            tests_failed++;
            $display("FAIL frame_start: got %0d pulses at %0d want 1 pulse at 0", fs_cnt, fs_pos);
        end
        tests_run++;
        if (consumed !== 32) begin
            tests_failed++;
            $display("FAIL frame_consumed: got %0d want 32", consumed);
        end
        for (int v = 0; v < 8; v++) begin
            logic [15:0] want;
            want = (v < 4) ? 16'h00FF : 16'h0000;
            tests_run++;
            if (de_mask[v] !== want) begin
                tests_failed++;
                $display("FAIL data_e line %0d: got %h want %h", v, de_mask[v], want);
            end
        end
    endtask

    task automatic test_sync();
        logic [15:0] hs_mask [8];
        int vs_cnt [8];
        for (int v = 0; v < 8; v++) begin
            hs_mask[v] = '0;
            vs_cnt[v]  = 0;
        end
        for (int p = 0; p <= FRAME; p++) begin
            if (p > 0) begin
                int q;
                q = p - 1;
                hs_mask[q / 16][q % 16] = hdmi_hsync;
                if (hdmi_vsync === 1'b1) vs_cnt[q / 16]++;
            end
            if (p < FRAME) begin
                pix_data = 24'h110000 + 24'(p);
                step();
            end
        end
        for (int v = 0; v < 8; v++) begin
            int want_vs;
            want_vs = (v == 5 || v == 6) ? 16 : 0;
            tests_run++;
            if (hs_mask[v] !== 16'h1C00) begin
                tests_failed++;
                $display("FAIL hsync line %0d: got %h want 1c00", v, hs_mask[v]);
            end
            tests_run++;
            if (vs_cnt[v] !== want_vs) begin
                tests_failed++;
                $display("FAIL vsync line %0d: got %0d want %0d", v, vs_cnt[v], want_vs);
            end
        end
    endtask

    task automatic test_underflow();
        for (int p = 0; p <= FRAME; p++) begin
            if (p == 19 || p == 25) begin
                tests_run++;
                if (underflow !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL underflow_low at %0d: got %b want 0", p, underflow);
                end
            end
            if (p == 20 || p == 22) begin
                tests_run++;
                if ({hdmi_data_e, hdmi_data} !== {1'b1, 24'h0}) begin
                    tests_failed++;
                    $display("FAIL starved_slot at %0d: got de=%b data=%h want de=1 data=0",
                             p - 1, hdmi_data_e, hdmi_data);
                end
            end
            if (p == 20 || p == 22 || p == 24) begin
                tests_run++;
                if (underflow !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL underflow_high at %0d: got %b want 1", p, underflow);
                end
            end
            if (p == 21) begin
                tests_run++;
                if (hdmi_data !== 24'h200014) begin
                    tests_failed++;
                    $display("FAIL fed_slot: got %h want 200014", hdmi_data);
                end
            end
            if (p < FRAME) begin
                pix_data      = 24'h200000 + 24'(p);
                pix_valid     = !(p == 19 || p == 21);
                underflow_clr = (p == 21 || p == 24);
                step();
            end
        end
        pix_valid     = 1'b1;
        underflow_clr = 1'b0;
    endtask

    task automatic test_stop();
        for (int p = 0; p <= FRAME; p++) begin
            if (p == 91) begin
                tests_run++;
                if ({hdmi_hsync, hdmi_vsync} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL sync_in_stop: got %b want 11", {hdmi_hsync, hdmi_vsync});
                end
            end
            if (p == FRAME - 1) begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stop_busy_eof: got %b want 1", busy);
                end
            end
            if (p == FRAME) begin
                tests_run++;
                if ({busy, pix_ready} !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL stop_idle: got busy/ready %b want 00", {busy, pix_ready});
                end
            end
            if (p < FRAME) begin
                if (p == 37) enable = 1'b0;
                pix_data = 24'h400000 + 24'(p);
                step();
            end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if ({busy, pix_ready, hdmi_hsync, hdmi_vsync, hdmi_data_e, frame_start}
                !== 6'b0) begin
                tests_failed++;
                $display("FAIL stopped_outputs: got %b want 000000",
                         {busy, pix_ready, hdmi_hsync, hdmi_vsync, hdmi_data_e, frame_start});
            end
        end
        enable = 1'b1;
        step();
        for (int p = 0; p <= 2 * FRAME; p++) begin
            if (p == 127 || p == 255) begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL pend_busy at %0d: got %b want 1", p, busy);
                end
            end
            if (p == 128 || p == 256) begin
                tests_run++;
                if ({busy, pix_ready} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL resume at %0d: got busy/ready %b want 11", p,
                             {busy, pix_ready});
                end
            end
            if (p == 129) begin
                tests_run++;
                if ({frame_start, hdmi_data_e} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL resume_frame_start: got fs/de %b want 11",
                             {frame_start, hdmi_data_e});
                end
            end
            if (p < 2 * FRAME) begin
                if (p == 37 || p == 140) enable = 1'b0;
                if (p == 96 || p == 255) enable = 1'b1;
                pix_data = 24'h500000 + 24'(p);
                step();
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 36; p++) begin
            pix_data  = 24'h300000 + 24'(p);
            pix_valid = (p != 34);
            step();
        end
        pix_valid = 1'b1;
        tests_run++;
        if ({busy, hdmi_data_e, underflow} !== 3'b111) begin
            tests_failed++;
            $display("FAIL pre_reset: got busy/de/uf %b want 111",
                     {busy, hdmi_data_e, underflow});
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, pix_ready, hdmi_hsync, hdmi_vsync, hdmi_data_e, frame_start, underflow}
            !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_async_flags: got %b want 0000000",
                     {busy, pix_ready, hdmi_hsync, hdmi_vsync, hdmi_data_e, frame_start,
                      underflow});
        end
        tests_run++;
        if (hdmi_data !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_async_data: got %h want 000000", hdmi_data);
        end
        repeat (2) step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold_busy: got %b want 0", busy);
        end
        reset_n = 1'b1;
        step();
        tests_run++;
        if ({busy, pix_ready, frame_start} !== 3'b110) begin
            tests_failed++;
            $display("FAIL restart_origin: got busy/ready/fs %b want 110",
                     {busy, pix_ready, frame_start});
        end
        pix_data = 24'h3B0000;
        step();
        tests_run++;
        if ({frame_start, hdmi_data_e, underflow, hdmi_data} !== {3'b110, 24'h3B0000}) begin
            tests_failed++;
            $display("FAIL restart_first_pixel: got fs/de/uf %b data %h want 110 data 3b0000",
                     {frame_start, hdmi_data_e, underflow}, hdmi_data);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_sync();
        test_underflow();
        test_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
